// File: rtl/i2c_sonar_responder.sv
// I2C target emulating an SRF-style ultrasonic ranger.
// SCL/SDA are oversampled by clk. START/STOP are decoded from the
// synchronized lines and take priority over bit events. sda_oe only
// changes on a detected SCL fall, so SDA never moves while SCL is high.
module i2c_sonar_responder #(
  parameter logic [6:0] DEV_ADDR     = 7'h70,
  parameter int         RANGE_CYCLES = 20,
  parameter logic [7:0] FW_REV       = 8'h06
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] range_value,
  output logic        busy,
  output logic        cmd_strobe,
  output logic [7:0]  reg_ptr
);

  localparam int CW = (RANGE_CYCLES < 2) ? 1 : $clog2(RANGE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  state_t        r_state, w_state_n;
  logic          r_scl_s1, r_scl_s2, r_scl_h;
  logic          r_sda_s1, r_sda_s2, r_sda_h;
  logic [3:0]    r_bitcnt, w_bitcnt_n;
  logic [7:0]    r_sh, w_sh_n;
  logic          r_oe, w_oe_n;
  logic          r_first, w_first_n;
  logic          r_rw, w_rw_n;
  logic [7:0]    r_ptr, w_ptr_n;
  logic          w_cmd_go;
  logic          r_strobe, r_busy;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_range;
  logic [7:0]    w_rd_data;
  logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_is_cmd;

  // Two-flop synchronizers plus one history flop per line; idle bus is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;   r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
      r_sda_s1 <= sda_in;   r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
  assign w_is_cmd   = (r_sh == 8'h50) || (r_sh == 8'h51) || (r_sh == 8'h52);

  // Read map addressed by the current pointer.
  always_comb begin
    w_rd_data = 8'h00;
    case (r_ptr)
      8'h00:   w_rd_data = FW_REV;
      8'h01:   w_rd_data = 8'h80;
      8'h02:   w_rd_data = r_range[15:8];
      8'h03:   w_rd_data = r_range[7:0];
      default: w_rd_data = 8'h00;
    endcase
  end

  // Next-state and datapath update for the bus protocol FSM.
  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_sh_n     = r_sh;
    w_oe_n     = r_oe;
    w_first_n  = r_first;
    w_rw_n     = r_rw;
    w_ptr_n    = r_ptr;
    w_cmd_go   = 1'b0;
    if (w_stop) begin
      w_state_n = S_IDLE;
      w_oe_n    = 1'b0;
    end else if (w_start) begin
      w_state_n  = S_ADDR;
      w_oe_n     = 1'b0;
      w_bitcnt_n = 4'd0;
      w_first_n  = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_sh_n     = {r_sh[6:0], r_sda_s2};
            w_bitcnt_n = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_bitcnt_n = 4'd0;
            if (r_sh[7:1] == DEV_ADDR && !r_busy) begin
              w_state_n = S_ADDR_ACK;
              w_oe_n    = 1'b1;
              w_rw_n    = r_sh[0];
            end else begin
              w_state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bitcnt_n = 4'd0;
            if (r_rw) begin
              // First read bit goes out on the fall that ends the ACK.
              w_state_n = S_RD_BYTE;
              w_sh_n    = {w_rd_data[6:0], 1'b0};
              w_oe_n    = ~w_rd_data[7];
            end else begin
              w_state_n = S_WR_BYTE;
              w_oe_n    = 1'b0;
            end
          end
        end
        S_WR_BYTE: begin
          if (w_scl_rise) begin
            w_sh_n     = {r_sh[6:0], r_sda_s2};
            w_bitcnt_n = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_state_n  = S_WR_ACK;
            w_oe_n     = 1'b1;
            w_bitcnt_n = 4'd0;
            if (r_first) begin
              w_ptr_n   = r_sh;
              w_first_n = 1'b0;
            end else begin
              w_cmd_go = (r_ptr == 8'h00) && w_is_cmd;
              w_ptr_n  = r_ptr + 8'd1;
            end
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall) begin
            w_state_n = S_WR_BYTE;
            w_oe_n    = 1'b0;
          end
        end
        S_RD_BYTE: begin
          if (w_scl_rise) begin
            w_bitcnt_n = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_state_n  = S_RD_ACK;
              w_oe_n     = 1'b0;
              w_bitcnt_n = 4'd0;
            end else begin
              w_oe_n = ~r_sh[7];
              w_sh_n = {r_sh[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          // bitcnt==1 marks "master ACKed, reload on the next fall".
          if (w_scl_rise) begin
            w_ptr_n = r_ptr + 8'd1;
            if (r_sda_s2) w_state_n = S_IGNORE;
            else          w_bitcnt_n = 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd1) begin
            w_state_n  = S_RD_BYTE;
            w_bitcnt_n = 4'd0;
            w_sh_n     = {w_rd_data[6:0], 1'b0};
            w_oe_n     = ~w_rd_data[7];
          end
        end
        default: w_oe_n = 1'b0;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Protocol datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitcnt <= 4'd0;
      r_sh     <= 8'h00;
      r_oe     <= 1'b0;
      r_first  <= 1'b0;
      r_rw     <= 1'b0;
      r_ptr    <= 8'h00;
    end else begin
      r_bitcnt <= w_bitcnt_n;
      r_sh     <= w_sh_n;
      r_oe     <= w_oe_n;
      r_first  <= w_first_n;
      r_rw     <= w_rw_n;
      r_ptr    <= w_ptr_n;
    end
  end

  // Ranging timer: busy for exactly RANGE_CYCLES clocks, range captured as it ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_range  <= 16'h0000;
    end else begin
      r_strobe <= w_cmd_go;
      if (w_cmd_go) begin
        r_busy <= 1'b1;
        r_cnt  <= CW'(RANGE_CYCLES);
      end else if (r_busy) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy  <= 1'b0;
          r_range <= range_value;
        end
      end
    end
  end

  assign sda_oe     = r_oe;
  assign busy       = r_busy;
  assign cmd_strobe = r_strobe;
  assign reg_ptr    = r_ptr;

endmodule

// File: tb/tb_i2c_sonar_responder.sv
// Bench for i2c_sonar_responder: bit-banged I2C master driving two
// targets on one open-drain bus. Target A uses default parameters;
// target B (address 0x38) has a long ranging time so its busy window
// can be hit by a following address byte.
module tb_i2c_sonar_responder;

  logic        clk = 1'b0, reset = 1'b1, scl = 1'b1, m_sda = 1'b1;
  logic [15:0] rv_a = 16'h012C, rv_b = 16'h4321;
  logic        oe_a, oe_b, busy_a, busy_b, stb_a, stb_b;
  logic [7:0]  ptr_a, ptr_b;
  wire         sda = m_sda & ~oe_a & ~oe_b;

  int n_vec = 0, n_err = 0;
  int busy_cyc_a = 0, stb_cnt_a = 0, stb_cnt_b = 0;
  logic seen_a = 1'b0, seen_b = 1'b0;
  logic [7:0] exp_q[$];
  logic a;
  logic [7:0] d, e;

  i2c_sonar_responder dut_a (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda), .sda_oe(oe_a),
    .range_value(rv_a), .busy(busy_a), .cmd_strobe(stb_a), .reg_ptr(ptr_a));

  i2c_sonar_responder #(.DEV_ADDR(7'h38), .RANGE_CYCLES(300)) dut_b (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda), .sda_oe(oe_b),
    .range_value(rv_b), .busy(busy_b), .cmd_strobe(stb_b), .reg_ptr(ptr_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (busy_a) busy_cyc_a++;
    if (stb_a)  stb_cnt_a++;
    if (stb_b)  stb_cnt_b++;
    if (oe_a)   seen_a = 1'b1;
    if (oe_b)   seen_b = 1'b1;
  end

  // ---- bus primitives (SCL period 100 ns = 10 clk) ----
  task automatic i2c_start();
    m_sda = 1'b1; #25; scl = 1'b1; #25; m_sda = 1'b0; #25; scl = 1'b0; #25;
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; #25; scl = 1'b1; #25; m_sda = 1'b1; #25;
  endtask
  task automatic write_bit(input logic b);
    m_sda = b; #25; scl = 1'b1; #50; scl = 1'b0; #25;
  endtask
  task automatic read_bit(output logic b);
    m_sda = 1'b1; #25; scl = 1'b1; #25; b = sda; #25; scl = 1'b0; #25;
  endtask
  task automatic wr_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) read_bit(v[i]);
    write_bit(nack);
  endtask
  // Stimulus only: point A at a register and turn the bus around for reading.
  task automatic a_ptr_then_read(input logic [7:0] p);
    logic k;
    i2c_start(); wr_byte(8'hE0, k); wr_byte(p, k);
    i2c_start(); wr_byte(8'hE1, k);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    #25;
    n_vec++; if (oe_a !== 1'b0)   begin n_err++; $display("FAIL rst_oe got %b exp 0", oe_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy_a); end
    n_vec++; if (stb_a !== 1'b0)  begin n_err++; $display("FAIL rst_strobe got %b exp 0", stb_a); end
    n_vec++; if (ptr_a !== 8'h00) begin n_err++; $display("FAIL rst_ptr got %h exp 00", ptr_a); end
    reset = 1'b0; #50;
  endtask

  task automatic test_command();
    busy_cyc_a = 0; stb_cnt_a = 0;
    i2c_start();
    wr_byte(8'hE0, a); n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL cmd_ack_addr got %b exp 0", a); end
    wr_byte(8'h00, a); n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL cmd_ack_ptr got %b exp 0", a); end
    wr_byte(8'h51, a); n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL cmd_ack_cmd got %b exp 0", a); end
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL cmd_busy_set got %b exp 1", busy_a); end
    i2c_stop();
    #400;
    n_vec++; if (busy_cyc_a != 20) begin n_err++; $display("FAIL cmd_busy_len got %0d exp 20", busy_cyc_a); end
    n_vec++; if (stb_cnt_a != 1)   begin n_err++; $display("FAIL cmd_strobe_cnt got %0d exp 1", stb_cnt_a); end
    n_vec++; if (ptr_a !== 8'h01)  begin n_err++; $display("FAIL cmd_ptr got %h exp 01", ptr_a); end
    rv_a = 16'hBEEF;  // must not leak: range was captured when ranging ended
  endtask

  task automatic test_busy_nack();
    stb_cnt_b = 0;
    i2c_start(); wr_byte(8'h70, a); wr_byte(8'h00, a); wr_byte(8'h50, a); i2c_stop();
    n_vec++; if (stb_cnt_b != 1) begin n_err++; $display("FAIL busy_strobe got %0d exp 1", stb_cnt_b); end
    seen_b = 1'b0;
    i2c_start();
    wr_byte(8'h70, a);
    n_vec++; if (a !== 1'b1)      begin n_err++; $display("FAIL busy_nack got %b exp 1", a); end
    n_vec++; if (busy_b !== 1'b1) begin n_err++; $display("FAIL busy_still got %b exp 1", busy_b); end
    wr_byte(8'h00, a);  // target should be ignoring the rest of the transfer
    n_vec++; if (a !== 1'b1)      begin n_err++; $display("FAIL busy_ignore got %b exp 1", a); end
    i2c_stop();
    n_vec++; if (seen_b !== 1'b0) begin n_err++; $display("FAIL busy_oe got %b exp 0", seen_b); end
    #3500;
  endtask

  task automatic test_read_range();
    a_ptr_then_read(8'h02);
    exp_q.push_back(8'h01); exp_q.push_back(8'h2C);
    rd_byte(1'b0, d); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL range_hi got %h exp %h", d, e); end
    rd_byte(1'b1, d); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL range_lo got %h exp %h", d, e); end
    i2c_stop(); #50;
    n_vec++; if (ptr_a !== 8'h04) begin n_err++; $display("FAIL range_ptr got %h exp 04", ptr_a); end
  endtask

  task automatic test_wrong_addr();
    seen_a = 1'b0; seen_b = 1'b0;
    i2c_start();
    wr_byte(8'hE2, a);
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL wrong_nack got %b exp 1", a); end
    wr_byte(8'h00, a); i2c_stop(); #50;
    n_vec++; if ((seen_a | seen_b) !== 1'b0) begin n_err++; $display("FAIL wrong_oe got %b exp 0", seen_a | seen_b); end
    n_vec++; if (ptr_a !== 8'h04) begin n_err++; $display("FAIL wrong_ptr got %h exp 04", ptr_a); end
  endtask

  task automatic test_read_map();
    a_ptr_then_read(8'h00); exp_q.push_back(8'h06);
    rd_byte(1'b1, d); i2c_stop(); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL map_reg0 got %h exp %h", d, e); end
    a_ptr_then_read(8'h05); exp_q.push_back(8'h00);
    rd_byte(1'b1, d); i2c_stop(); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL map_reg5 got %h exp %h", d, e); end
    a_ptr_then_read(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'h01);
    rd_byte(1'b0, d); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL map_reg1 got %h exp %h", d, e); end
    rd_byte(1'b1, d); i2c_stop(); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL map_reg2 got %h exp %h", d, e); end
    // pointer wraps FF -> 00 across an acked read
    a_ptr_then_read(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h06);
    rd_byte(1'b0, d); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL wrap_regFF got %h exp %h", d, e); end
    rd_byte(1'b1, d); i2c_stop(); e = exp_q.pop_front(); #50;
    n_vec++; if (d !== e) begin n_err++; $display("FAIL wrap_reg00 got %h exp %h", d, e); end
    n_vec++; if (ptr_a !== 8'h01) begin n_err++; $display("FAIL wrap_ptr got %h exp 01", ptr_a); end
  endtask

  task automatic test_reset_mid();
    logic b;
    a_ptr_then_read(8'h05);  // all-zero byte: target pulls low on every bit
    for (int i = 0; i < 4; i++) read_bit(b);
    #10;
    n_vec++; if (oe_a !== 1'b1) begin n_err++; $display("FAIL mid_drive got %b exp 1", oe_a); end
    reset = 1'b1; #1;
    n_vec++; if (oe_a !== 1'b0) begin n_err++; $display("FAIL mid_release got %b exp 0", oe_a); end
    #14; reset = 1'b0; #25;
    n_vec++; if (ptr_a !== 8'h00) begin n_err++; $display("FAIL mid_ptr got %h exp 00", ptr_a); end
    i2c_stop();
    a_ptr_then_read(8'h02); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rd_byte(1'b0, d); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL post_reg2 got %h exp %h", d, e); end
    rd_byte(1'b1, d); i2c_stop(); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL post_reg3 got %h exp %h", d, e); end
    a_ptr_then_read(8'h00); exp_q.push_back(8'h06);
    rd_byte(1'b1, d); i2c_stop(); e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL post_reg0 got %h exp %h", d, e); end
  endtask

  initial begin
    #2;
    test_reset();
    test_command();
    test_busy_nack();
    test_read_range();
    test_wrong_addr();
    test_read_map();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
